// File: rtl/pll_seq_pkg.sv
// PLL lock sequencer shared types.
// State encodings are also used by the debug readout.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    S_RESET_HOLD = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_STABLE     = 3'd2,
    S_RUN        = 3'd3,
    S_LOST       = 3'd4,
    S_FAULT      = 3'd5
  } pll_state_e;

  localparam int unsigned RST_CYCLES_DEF    = 16;
  localparam int unsigned LOCK_TIMEOUT_DEF  = 65536;
  localparam int unsigned STABLE_CYCLES_DEF = 1024;
  localparam int unsigned MAX_RETRY_DEF     = 3;
  localparam int unsigned CNT_W_DEF         = 8;

  function automatic int unsigned max3(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Generic 1-bit two-flop synchroniser.
// Synchronous active-low reset clears both stages.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer on the reference clock.
// Holds PLL reset, qualifies lock, releases sys reset.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = RST_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned MAX_RETRY     = MAX_RETRY_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             restart,
  output logic             pll_areset,
  output logic             sys_rst_n,
  output logic             ready,
  output logic             fault,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] loss_count
);

  localparam int unsigned CMAX =
    max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CW = (CMAX > 2) ? $clog2(CMAX) : 1;
  localparam int RW = $clog2(MAX_RETRY + 2);

  localparam logic [CW-1:0] RST_LAST =
    CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST =
    CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST =
    CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX =
    RW'(MAX_RETRY);

  logic lk;

  pll_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [RW-1:0]    retry_inc;
  logic [CNT_W-1:0] loss_q, loss_d;

  logic areset_q;
  logic sysrst_n_q;
  logic ready_q;
  logic fault_q;

  sync_2ff u_lock_sync (
    .clk_i  (clkin),
    .rst_ni (rst),
    .d_i    (pll_locked),
    .q_o    (lk)
  );

  // next-state, shared counter, retry and loss bookkeeping
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    loss_d    = loss_q;
    retry_inc = retry_q + 1'b1;
    case (state_q)
      S_RESET_HOLD: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (lk) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          retry_d = retry_inc;
          cnt_d   = '0;
          if (retry_inc > RETRY_MAX)
            state_d = S_FAULT;
          else
            state_d = S_RESET_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STABLE: begin
        if (!lk) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!lk) begin
          state_d = S_LOST;
          cnt_d   = '0;
        end
      end
      S_LOST: begin
        state_d = S_RESET_HOLD;
        cnt_d   = '0;
        if (loss_q != '1)
          loss_d = loss_q + 1'b1;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_RESET_HOLD;
        cnt_d   = '0;
      end
    endcase
    if (restart) begin
      state_d = S_RESET_HOLD;
      cnt_d   = '0;
      retry_d = '0;
    end
  end

  // state register with outputs decoded from the next state
  always_ff @(posedge clkin) begin
    if (!rst) begin
      state_q    <= S_RESET_HOLD;
      cnt_q      <= '0;
      retry_q    <= '0;
      loss_q     <= '0;
      areset_q   <= 1'b1;
      sysrst_n_q <= 1'b0;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      loss_q     <= loss_d;
      areset_q   <= (state_d == S_RESET_HOLD) ||
                    (state_d == S_FAULT);
      sysrst_n_q <= (state_d == S_RUN);
      ready_q    <= (state_d == S_RUN);
      fault_q    <= (state_d == S_FAULT);
    end
  end

  assign pll_areset = areset_q;
  assign sys_rst_n  = sysrst_n_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign state_o    = state_q;
  assign loss_count = loss_q;

endmodule
